// File: rtl/chan_scan_mux_pkg.sv
// Shared encodings for the channel scan mux: FSM state codes, mode values and the
// next-state rule.
package msoc_pkg;

   localparam logic [1:0] CSM_MAN  = 2'd0;
   localparam logic [1:0] CSM_SCAN = 2'd1;
   localparam logic [1:0] CSM_HOLD = 2'd2;

   localparam logic MODE_MAN  = 1'b0;
   localparam logic MODE_SCAN = 1'b1;

   function automatic logic [1:0] csm_next(input logic [1:0] st,
                                            input logic       mode,
                                            input logic       freeze);
      logic [1:0] nxt;
      case (st)
         CSM_MAN:  nxt = freeze ? CSM_HOLD : ((mode == MODE_SCAN) ? CSM_SCAN : CSM_MAN);
         CSM_SCAN: nxt = freeze ? CSM_HOLD : ((mode == MODE_MAN)  ? CSM_MAN  : CSM_SCAN);
         CSM_HOLD: nxt = freeze ? CSM_HOLD : ((mode == MODE_SCAN) ? CSM_SCAN : CSM_MAN);
         // An unused encoding falls back to manual selection.
         default:  nxt = CSM_MAN;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/chan_scan_mux_if.sv
// Bundle of data taps, control inputs and selected outputs for chan_scan_mux.
// master drives taps/controls; slave (the mux) drives the selected outputs.
interface chan_scan_mux_if #(
   parameter int DW    = 32,
   parameter int NCH   = 8,
   parameter int DIV_W = 16
);
   localparam int SW = $clog2(NCH);

   logic [NCH*DW-1:0] in_bus;
   logic              mode;
   logic [SW-1:0]     sel_in;
   logic [DIV_W-1:0]  scan_div;
   logic              freeze;
   logic [DW-1:0]     out_data;
   logic [SW-1:0]     out_ch;
   logic              ch_stb;

   modport master (
      output in_bus, mode, sel_in, scan_div, freeze,
      input  out_data, out_ch, ch_stb
   );

   modport slave (
      input  in_bus, mode, sel_in, scan_div, freeze,
      output out_data, out_ch, ch_stb
   );

endinterface

// File: rtl/chan_scan_mux_div.sv
// Scan dwell prescaler: tick fires on the terminal count while enabled.
// Counter holds when disabled, clears when clr is high.
module scan_tick_div #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);

   logic [DIV_W-1:0] cnt_q, cnt_d;

   // >= so that shrinking div below the running count ends the dwell on the next edge.
   assign tick = en & (cnt_q >= div);

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (tick) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/chan_scan_mux.sv
// Registered N-channel selector with manual select, round-robin scan and freeze.
// One cycle from channel decision to out_data/out_ch/ch_stb, all updated together.
module chan_scan_mux
   import msoc_pkg::*;
#(
   parameter int DW    = 32,
   parameter int NCH   = 8,
   parameter int DIV_W = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   chan_scan_mux_if.slave  bus
);

   localparam int SW = $clog2(NCH);

   logic [1:0]    state_q, state_d;
   logic [SW-1:0] ch_q, ch_d;
   logic [DW-1:0] data_q, data_d;
   logic          stb_q, stb_d;
   logic          scan_en, scan_clr, tick;

   // The datapath acts on the state being entered, so freeze and mode take effect on
   // the same edge they are seen.
   assign state_d  = csm_next(state_q, bus.mode, bus.freeze);
   assign scan_en  = (state_d == CSM_SCAN);
   assign scan_clr = (state_d == CSM_MAN);

   scan_tick_div #(.DIV_W(DIV_W)) u_div (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (scan_en),
      .clr   (scan_clr),
      .div   (bus.scan_div),
      .tick  (tick)
   );

   always_comb begin
      ch_d = ch_q;
      if (state_d == CSM_MAN) begin
         if (int'(bus.sel_in) < NCH) begin
            ch_d = bus.sel_in;
         end
      end else if (state_d == CSM_SCAN && tick) begin
         ch_d = (ch_q == SW'(NCH - 1)) ? '0 : ch_q + 1'b1;
      end
   end

   always_comb begin
      data_d = data_q;
      stb_d  = 1'b0;
      if (state_d != CSM_HOLD) begin
         data_d = bus.in_bus[int'(ch_d)*DW +: DW];
         stb_d  = (ch_d != ch_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= CSM_MAN;
         ch_q    <= '0;
         data_q  <= '0;
         stb_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         data_q  <= data_d;
         stb_q   <= stb_d;
      end
   end

   assign bus.out_data = data_q;
   assign bus.out_ch   = ch_q;
   assign bus.ch_stb   = stb_q;

endmodule
